// File: rtl/gray_to_bin_seq_pkg.sv
// Shared definitions for the sequential Gray-to-binary decoder.
package gray_to_bin_seq_pkg;

    localparam int unsigned GRAY_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/gray_to_bin_seq_step_chk.sv
// Combinational test: are two Gray words exactly one bit apart?
// Compiled only when GRAY_STEP_CHK_EN is defined.
`ifdef GRAY_STEP_CHK_EN
module gray_to_bin_seq_step_chk #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             step_c
);

    logic [WIDTH-1:0] diff;

    // Exactly one differing bit <=> diff is a non-zero power of two.
    always_comb begin
        diff   = a ^ b;
        step_c = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    end

endmodule
`endif

// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder: accepts one Gray word per handshake,
// resolves it MSB-first one bit per clock, returns the binary word on a
// second handshake.
// Optional: define GRAY_STEP_CHK_EN to add step_err, which flags a Hamming
// distance other than one between consecutive accepted words.
module gray_to_bin_seq
    import gray_to_bin_seq_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             busy
`ifdef GRAY_STEP_CHK_EN
    ,
    output logic             step_err
`endif
);

    localparam int unsigned K_W = $clog2(WIDTH) + 1;

    state_e           state, state_n;
    logic [WIDTH-1:0] g_reg, g_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH-1:0] sel;
    logic [K_W-1:0]   k, k_n;
    logic [WIDTH-1:0] out_bin_n;
    logic             in_ready_n;
    logic             out_valid_n;
    logic             busy_n;

`ifdef GRAY_STEP_CHK_EN
    logic [WIDTH-1:0] prev_gray, prev_n;
    logic             have_prev, have_prev_n;
    logic             step_err_n;
    logic             step_ok_c;

    gray_to_bin_seq_step_chk #(.WIDTH(WIDTH)) u_step_chk (
        .a      (g_reg),
        .b      (prev_gray),
        .step_c (step_ok_c)
    );
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_n   = state;
        g_n       = g_reg;
        acc_n     = acc;
        k_n       = k;
        out_bin_n = out_bin;
        acc_ext   = {1'b0, acc};
        sel       = WIDTH'(1) << k;
`ifdef GRAY_STEP_CHK_EN
        prev_n      = prev_gray;
        have_prev_n = have_prev;
        step_err_n  = step_err;
`endif

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    g_n     = in_gray;
                    acc_n   = '0;
                    k_n     = K_W'(WIDTH - 1);
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Bits below k are still zero, so OR-ing in bit k is exact.
                acc_n = acc | (sel & (acc_ext[WIDTH:1] ^ g_reg));
                if (k == '0) begin
                    state_n   = ST_DONE;
                    out_bin_n = acc_n;
`ifdef GRAY_STEP_CHK_EN
                    step_err_n  = have_prev && !step_ok_c;
                    prev_n      = g_reg;
                    have_prev_n = 1'b1;
`endif
                end else begin
                    k_n = k - K_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n = ST_IDLE;
`ifdef GRAY_STEP_CHK_EN
                    step_err_n = 1'b0;
`endif
                end
            end
            default: begin
                state_n = ST_IDLE;
`ifdef GRAY_STEP_CHK_EN
                step_err_n = 1'b0;
`endif
            end
        endcase

        in_ready_n  = (state_n == ST_IDLE);
        out_valid_n = (state_n == ST_DONE);
        busy_n      = (state_n != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            g_reg     <= '0;
            acc       <= '0;
            k         <= '0;
            out_bin   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef GRAY_STEP_CHK_EN
            prev_gray <= '0;
            have_prev <= 1'b0;
            step_err  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            g_reg     <= g_n;
            acc       <= acc_n;
            k         <= k_n;
            out_bin   <= out_bin_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
`ifdef GRAY_STEP_CHK_EN
            prev_gray <= prev_n;
            have_prev <= have_prev_n;
            step_err  <= step_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Bench for gray_to_bin_seq: WIDTH=4 and WIDTH=1 instances, randomized words
// checked against a search-based Gray inverse.
module tb_gray_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] in_gray, out_bin;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [0:0] in_gray1, out_bin1;
`ifdef GRAY_STEP_CHK_EN
    logic       step_err, step_err1;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_to_bin_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .busy(busy)
`ifdef GRAY_STEP_CHK_EN
        , .step_err(step_err)
`endif
    );

    gray_to_bin_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_gray(in_gray1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_bin(out_bin1),
        .busy(busy1)
`ifdef GRAY_STEP_CHK_EN
        , .step_err(step_err1)
`endif
    );

    // Reference: the binary value whose Gray code equals g, found by search.
    function automatic logic [3:0] ref_bin4(input logic [3:0] g);
        for (int b = 0; b < 16; b++) begin
            logic [3:0] v;
            v = 4'(b);
            if ((v ^ (v >> 1)) == g) return v;
        end
        return 4'h0;
    endfunction

    // Stimulus helpers (no checking inside, except the accept timeout).
    task automatic push4(input logic [3:0] g, output int acc_cyc);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL push4_ready_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        in_gray  = g;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_gray  = 4'($urandom);
    endtask

    task automatic wait_valid4(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic pop4();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_bin !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_w4 got rdy=%0b vld=%0b busy=%0b bin=%h required 1 0 0 0",
                     in_ready, out_valid, busy, out_bin);
        end
        vectors++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0 || out_bin1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w1 got rdy=%0b vld=%0b busy=%0b bin=%b required 1 0 0 0",
                     in_ready1, out_valid1, busy1, out_bin1);
        end
`ifdef GRAY_STEP_CHK_EN
        vectors++;
        if (step_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_step_err got %0b required 0", step_err);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exhaustive();
        int lat, a;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] b, g;
            b = 4'(i);
            g = b ^ (b >> 1);
            push4(g, a);
            vectors++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL exh_busy g=%h got busy=%0b rdy=%0b required 1 0", g, busy, in_ready);
            end
            wait_valid4(lat);
            vectors++;
            if (lat !== 4) begin
                miscompares++;
                $display("FAIL exh_latency g=%h got %0d edges required 4", g, lat);
            end
            vectors++;
            if (out_bin !== ref_bin4(g)) begin
                miscompares++;
                $display("FAIL exh_data g=%h got %h required %h", g, out_bin, ref_bin4(g));
            end
            pop4();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL exh_release g=%h got vld=%0b rdy=%0b busy=%0b required 0 1 0",
                         g, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_single_words();
        logic [3:0] gs [3] = '{4'b1000, 4'b0000, 4'b1100};
        logic [3:0] es [3] = '{4'b1111, 4'b0000, 4'b1000};
        int lat, a;
        for (int i = 0; i < 3; i++) begin
            push4(gs[i], a);
            wait_valid4(lat);
            vectors++;
            if (out_valid !== 1'b1 || out_bin !== es[i]) begin
                miscompares++;
                $display("FAIL single_word g=%b got vld=%0b bin=%b required 1 %b",
                         gs[i], out_valid, out_bin, es[i]);
            end
            pop4();
        end
    endtask

    task automatic test_random();
        int lat, a, dly;
        logic [3:0] g, held;
        for (int n = 0; n < 24; n++) begin
            g = 4'($urandom_range(0, 15));
            push4(g, a);
            wait_valid4(lat);
            vectors++;
            if (lat !== 4 || out_bin !== ref_bin4(g)) begin
                miscompares++;
                $display("FAIL rand_word g=%h got lat=%0d bin=%h required 4 %h",
                         g, lat, out_bin, ref_bin4(g));
            end
            held = out_bin;
            dly  = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) begin
                @(posedge clk); #1;
                vectors++;
                if (out_valid !== 1'b1 || out_bin !== held) begin
                    miscompares++;
                    $display("FAIL rand_hold g=%h got vld=%0b bin=%h required 1 %h",
                             g, out_valid, out_bin, held);
                end
            end
            pop4();
        end
    endtask

    task automatic test_backpressure();
        int lat, a;
        logic [3:0] g, held;
        g = 4'b0110;
        push4(g, a);
        wait_valid4(lat);
        held = out_bin;
        // Offer a competing word that must not be taken while DONE.
        in_valid = 1'b1;
        in_gray  = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_bin !== held || held !== ref_bin4(g) || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d got vld=%0b bin=%h rdy=%0b required 1 %h 0",
                         c, out_valid, out_bin, in_ready, ref_bin4(g));
            end
        end
        in_valid = 1'b0;
        pop4();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== held) begin
            miscompares++;
            $display("FAIL bp_release got rdy=%0b vld=%0b bin=%h required 1 0 %h",
                     in_ready, out_valid, out_bin, held);
        end
    endtask

    task automatic test_back_to_back();
        int lat, a, prev_a;
        logic [3:0] g;
        out_ready = 1'b1;
        prev_a = -1;
        for (int n = 0; n < 5; n++) begin
            g = 4'($urandom_range(0, 15));
            push4(g, a);
            if (prev_a >= 0) begin
                vectors++;
                if (a - prev_a !== 6) begin
                    miscompares++;
                    $display("FAIL b2b_period got %0d cycles required 6", a - prev_a);
                end
            end
            prev_a = a;
            wait_valid4(lat);
            vectors++;
            if (lat !== 4 || out_bin !== ref_bin4(g)) begin
                miscompares++;
                $display("FAIL b2b_word g=%h got lat=%0d bin=%h required 4 %h",
                         g, lat, out_bin, ref_bin4(g));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, a;
        logic [3:0] g;
        g = 4'b1011;
        push4(g, a);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_bin !== 4'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got vld=%0b bin=%h rdy=%0b busy=%0b required 0 0 1 0",
                     out_valid, out_bin, in_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        g = 4'b0101;
        push4(g, a);
        wait_valid4(lat);
        vectors++;
        if (lat !== 4 || out_bin !== ref_bin4(g)) begin
            miscompares++;
            $display("FAIL mid_reset_next g=%h got lat=%0d bin=%h required 4 %h",
                     g, lat, out_bin, ref_bin4(g));
        end
        pop4();
    endtask

`ifdef GRAY_STEP_CHK_EN
    task automatic test_step_chk();
        logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0000,
                                4'b0100, 4'b1100, 4'b0011};
        logic [3:0] prev;
        logic       have, exp_err;
        int lat, a;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        have = 1'b0;
        prev = 4'h0;
        for (int i = 0; i < 8; i++) begin
            push4(seq[i], a);
            wait_valid4(lat);
            exp_err = have && ($countones(seq[i] ^ prev) != 1);
            vectors++;
            if (step_err !== exp_err) begin
                miscompares++;
                $display("FAIL step_err word%0d g=%b prev=%b got %0b required %0b",
                         i, seq[i], prev, step_err, exp_err);
            end
            prev = seq[i];
            have = 1'b1;
            pop4();
            vectors++;
            if (step_err !== 1'b0) begin
                miscompares++;
                $display("FAIL step_err_idle word%0d got %0b required 0", i, step_err);
            end
        end
    endtask
`endif

    task automatic test_width1();
        logic [0:0] g;
        int lat;
        for (int n = 0; n < 6; n++) begin
            g = (n < 2) ? 1'(n + 1) : 1'($urandom);
            in_valid1 = 1'b1;
            in_gray1  = g;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            in_gray1  = ~g;
            lat = 0;
            while (!out_valid1 && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            vectors++;
            if (lat !== 1 || out_bin1 !== g) begin
                miscompares++;
                $display("FAIL w1_word g=%b got lat=%0d bin=%b required 1 %b", g, lat, out_bin1, g);
            end
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
            vectors++;
            if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
                miscompares++;
                $display("FAIL w1_release got vld=%0b rdy=%0b required 0 1", out_valid1, in_ready1);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_gray    = 4'h0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_gray1   = 1'b0;
        out_ready1 = 1'b0;
        test_reset();
        test_exhaustive();
        test_single_words();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef GRAY_STEP_CHK_EN
        test_step_chk();
`endif
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no completion required finish");
        $fatal(1);
    end

endmodule
